// File: rtl/as1x00_sram_pkg.sv
// Shared definitions for the port-0 SRAM arbiter: FSM states, owner codes
// and the geometry of the 32x512 OpenRAM macro.
package as1x00_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } sram_state_e;

    // Identity of the requester that owns the access in flight.
    localparam logic OWN_WB   = 1'b0;
    localparam logic OWN_CORE = 1'b1;

    localparam int SRAM_ADR_W  = 9;
    localparam int SRAM_DW     = 32;
    localparam int SRAM_MASK_W = 4;

endpackage

// File: rtl/sram_port0_arbiter_rr_arb2.sv
// Two-input picker: Wishbone vs core. Strict Wishbone priority when
// prio_wb_i is set, otherwise round-robin on ties using a last-grant flag.
module rr_arb2
    import as1x00_sram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic prio_wb_i,
    input  logic req_wb_i,
    input  logic req_core_i,
    output logic gnt_wb_o,
    output logic gnt_core_o
);

    logic last_q;
    logic last_d;

    // Pick a winner while enabled and remember who got the last grant.
    always_comb begin
        gnt_wb_o   = 1'b0;
        gnt_core_o = 1'b0;
        last_d     = last_q;
        if (en_i) begin
            if (req_wb_i && (prio_wb_i || !req_core_i || (last_q == OWN_CORE))) begin
                gnt_wb_o = 1'b1;
            end else if (req_core_i) begin
                gnt_core_o = 1'b1;
            end
            if (gnt_wb_o) begin
                last_d = OWN_WB;
            end else if (gnt_core_o) begin
                last_d = OWN_CORE;
            end
        end
    end

    // Last-grant register; resets to CORE so Wishbone wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= OWN_CORE;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Port-0 sharer for the OpenRAM macro: decodes the Wishbone window,
// arbitrates against the core data requester and drives registered SRAM
// controls through a three-state IDLE/REQ/RESP sequence.
module sram_port0_arbiter
    import as1x00_sram_pkg::*;
#(
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter int          ADR_W   = SRAM_ADR_W,
    parameter int          DATA_W  = SRAM_DW
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DATA_W-1:0]   wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [DATA_W-1:0]   wbs_dat_o,
    input  logic                wb_priority,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADR_W-1:0]    core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wmask,
    output logic                core_gnt,
    output logic                core_done,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                sram_csb0,
    output logic                sram_web0,
    output logic [DATA_W/8-1:0] sram_wmask0,
    output logic [ADR_W-1:0]    sram_addr0,
    output logic [DATA_W-1:0]   sram_din0,
    input  logic [DATA_W-1:0]   sram_dout0
);

    localparam int MASK_W = DATA_W / 8;

    sram_state_e        state_q, state_d;
    logic               owner_q, owner_d;
    logic               csb0_q, csb0_d;
    logic               web0_q, web0_d;
    logic [MASK_W-1:0]  wmask0_q, wmask0_d;
    logic [ADR_W-1:0]   addr0_q, addr0_d;
    logic [DATA_W-1:0]  din0_q, din0_d;
    logic [DATA_W-1:0]  core_rdata_q, core_rdata_d;

    logic               wb_hit;
    logic [ADR_W-1:0]   wb_word;
    logic               gnt_wb;
    logic               gnt_core;
    logic               in_idle;
    logic               unused_adr_bits;

    // Byte-offset bits never reach the word-addressed macro.
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    assign wb_hit  = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:ADR_W+2] == WB_BASE[31:ADR_W+2]);
    assign wb_word = wbs_adr_i[ADR_W+1:2];
    assign in_idle = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_n),
        .en_i       (in_idle),
        .prio_wb_i  (wb_priority),
        .req_wb_i   (wb_hit),
        .req_core_i (core_req),
        .gnt_wb_o   (gnt_wb),
        .gnt_core_o (gnt_core)
    );

    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;

    // Next-state, SRAM register loads and response outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        csb0_d       = 1'b1;
        web0_d       = web0_q;
        wmask0_d     = wmask0_q;
        addr0_d      = addr0_q;
        din0_d       = din0_q;
        core_rdata_d = core_rdata_q;
        wbs_ack_o    = 1'b0;
        wbs_dat_o    = '0;
        core_gnt     = 1'b0;
        core_done    = 1'b0;
        core_rdata   = core_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_wb) begin
                    state_d  = REQ;
                    owner_d  = OWN_WB;
                    csb0_d   = 1'b0;
                    web0_d   = ~wbs_we_i;
                    wmask0_d = wbs_we_i ? wbs_sel_i : {MASK_W{1'b1}};
                    addr0_d  = wb_word;
                    din0_d   = wbs_dat_i;
                end else if (gnt_core) begin
                    state_d  = REQ;
                    owner_d  = OWN_CORE;
                    csb0_d   = 1'b0;
                    web0_d   = ~core_we;
                    wmask0_d = core_we ? core_wmask : {MASK_W{1'b1}};
                    addr0_d  = core_addr;
                    din0_d   = core_wdata;
                end
            end
            REQ: begin
                // The macro samples csb0 at the edge closing this cycle.
                state_d  = RESP;
                core_gnt = (owner_q == OWN_CORE);
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_WB) begin
                    // An aborted cycle simply gets no ack; the access itself completed.
                    wbs_ack_o = wbs_cyc_i & wbs_stb_i;
                    if (web0_q) begin
                        wbs_dat_o = sram_dout0;
                    end
                end else begin
                    core_done = 1'b1;
                    if (web0_q) begin
                        core_rdata   = sram_dout0;
                        core_rdata_d = sram_dout0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and SRAM-facing registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_WB;
            csb0_q       <= 1'b1;
            web0_q       <= 1'b1;
            wmask0_q     <= '0;
            addr0_q      <= '0;
            din0_q       <= '0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            csb0_q       <= csb0_d;
            web0_q       <= web0_d;
            wmask0_q     <= wmask0_d;
            addr0_q      <= addr0_d;
            din0_q       <= din0_d;
            core_rdata_q <= core_rdata_d;
        end
    end

endmodule

// File: doc/sram_port0_arbiter.md
Name: sram_port0_arbiter

Overview:
Shares the read/write port (port 0) of the 2 kB 32x512 OpenRAM macro between two requesters. The first is the management-SoC Wishbone slave, used for program load and readback. The second is a core-side data requester from the TMS1x00 wrapper. The block decodes the Wishbone window, arbitrates between the two, drives registered SRAM control signals, and returns read data with ack/valid pulses. Port 1 (the core's program fetch) is untouched.

Parameters:
WB_BASE, 32'h3000_0000, Wishbone base address; bits [31:ADR_W+2] are compared for the window hit.
ADR_W, 9, SRAM word-address width (512 words).
DATA_W, 32, SRAM data width; byte mask width is DATA_W/8.

Ports:
wb_clk_i  in  1  single clock, shared with both SRAM ports.
wb_rst_n  in  1  reset, synchronous, active-low.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  Wishbone write enable.
wbs_sel_i  in  4  Wishbone byte selects.
wbs_adr_i  in  32  Wishbone byte address.
wbs_dat_i  in  32  Wishbone write data.
wbs_ack_o  out  1  Wishbone ack, 1-cycle pulse.
wbs_dat_o  out  32  Wishbone read data.
wb_priority  in  1  1 = Wishbone has strict priority; 0 = round-robin.
core_req  in  1  core access request, level-held until core_gnt.
core_we  in  1  core write.
core_addr  in  ADR_W  core word address.
core_wdata  in  32  core write data.
core_wmask  in  4  core byte mask.
core_gnt  out  1  request accepted (1-cycle pulse).
core_done  out  1  access complete (1-cycle pulse); core_rdata valid on reads.
core_rdata  out  32  core read data.
sram_csb0  out  1  SRAM port-0 chip select, active-low, registered.
sram_web0  out  1  SRAM write enable, active-low, registered.
sram_wmask0  out  4  SRAM byte mask, registered.
sram_addr0  out  ADR_W  SRAM address, registered.
sram_din0  out  32  SRAM write data, registered.
sram_dout0  in  32  SRAM read data, valid in the cycle after csb0 is sampled low.

Behaviour:
- wb_hit = cyc & stb & (adr[31:ADR_W+2] == WB_BASE[31:ADR_W+2]).
- SRAM word address from Wishbone is adr[ADR_W+1:2].
- FSM states:
  - IDLE: csb0=1. If a requester is eligible, load the SRAM registers and go to REQ.
  - REQ: csb0=0; the SRAM samples at the next edge. core_gnt=1 in REQ if the core owns the access. Always go to RESP.
  - RESP: csb0=1. Capture sram_dout0. For an owner of WB: wbs_ack_o = wbs_cyc_i & wbs_stb_i and wbs_dat_o = dout (reads) or 0 (writes). For an owner of CORE: core_done=1, and core_rdata = dout on reads. Always go to IDLE.
- Latency: request seen in IDLE at cycle 0 → ack/done in cycle 2. Back-to-back throughput is one access per 3 cycles.
- Arbitration in IDLE:
  - wb_priority=1: Wishbone always wins.
  - wb_priority=0: when both request, grant the requester not granted last. A last_grant register updates on every grant; its reset value is CORE, so Wishbone wins the first tie.
- Wishbone writes: web0=0, wmask0=sel. Wishbone reads: web0=1, wmask0=4'hF.
- A core request is taken only in IDLE. The core must hold req, we, addr, wdata and wmask stable until core_gnt.
- Wishbone out-of-window strobe (cyc&stb, not hit): no SRAM access, no ack. The bus decoder owns it.
- Wishbone abort (cyc dropped during REQ/RESP): the SRAM access completes (writes land) and ack is suppressed. The FSM still returns to IDLE.
- A new Wishbone strobe in the cycle after RESP is legal and re-arbitrated normally.
- Reset values: state=IDLE, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, wbs_ack_o=0, wbs_dat_o=0, core_gnt=0, core_done=0, core_rdata=0, last_grant=CORE.
- Reset during REQ: the SRAM still samples csb0=0 at the reset edge, so that access completes in the macro. No ack or done is issued.

Decomposition:
- Shared package as1x00_sram_pkg holds:
  - state enum {IDLE, REQ, RESP};
  - owner constants OWN_WB/OWN_CORE;
  - SRAM_ADR_W=9, SRAM_DW=32, SRAM_MASK_W=4.
- One sub-module, rr_arb2: a 2-input round-robin/priority picker with a last_grant register. The FSM and datapath stay in the top module.

Test Plan:
- WB write adr 0x3000_0010, dat 0xDEADBEEF, sel 4'hF, then read the same address → write ack at cycle 2; SRAM addr0=4, web0=0 in REQ; the read returns 0xDEADBEEF with ack 2 cycles after strobe.
- WB byte write sel 4'b0010, data 0x0000AB00 over 0x11223344, then read → wmask0=0010 in REQ; the read returns 0x1122AB44.
- Core and WB both request in IDLE, wb_priority=0, from reset → WB granted first, core next. Alternation holds over 4 ties; with wb_priority=1, WB wins all 4.
- Core read addr 9'h1FF after a WB write of 0xA5A5A5A5 there → core_gnt in REQ, core_done 1 cycle later, core_rdata=0xA5A5A5A5.
- WB strobe to 0x3100_0000 → csb0 stays 1 and no ack for 8 cycles. WB cyc dropped in REQ → no ack, FSM back in IDLE, the write still visible on readback.
- wb_rst_n low during REQ → the next cycle shows state IDLE, csb0=1 and all outputs at their reset values. A subsequent WB read completes normally.
